// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_pkg
//  Description : Mode and state encodings shared by the sequenced shift register
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ASR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_reg_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_step
//  Description : Combinational single-position shifter for one mode step
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out,
    output logic             active
);

    // Reserved modes fall through to the default and behave as HOLD.
    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        active  = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], serial_in};
                bit_out = q[WIDTH-1];
                active  = 1'b1;
            end
            MODE_SHR: begin
                q_next  = {serial_in, q[WIDTH-1:1]};
                bit_out = q[0];
                active  = 1'b1;
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
                active  = 1'b1;
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
                active  = 1'b1;
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                bit_out = q[0];
                active  = 1'b1;
            end
            default: begin
                q_next  = q;
                bit_out = 1'b0;
                active  = 1'b0;
            end
        endcase
    end

endmodule : shift_reg_step
`default_nettype wire

// File: rtl/shift_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_seq
//  Description : Load-then-shift register; shifts AMOUNT positions, one per clock
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_seq
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done,
    output logic             status
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_q;
    logic             r_serial_out;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_remaining;

    logic [WIDTH-1:0] w_q_next;
    logic             w_bit_out;
    logic             w_active;

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q         (r_q),
        .mode      (r_mode),
        .serial_in (serial_in),
        .q_next    (w_q_next),
        .bit_out   (w_bit_out),
        .active    (w_active)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!load && start) begin
                    w_state_next = (amount == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_remaining == AMT_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Mode and amount are captured at start so later input changes cannot disturb a run.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q          <= '0;
            r_serial_out <= 1'b0;
            r_mode       <= MODE_HOLD;
            r_remaining  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_q <= load_data;
                    end else if (start) begin
                        r_mode      <= mode;
                        r_remaining <= amount;
                    end
                end
                ST_SHIFT: begin
                    r_q         <= w_q_next;
                    r_remaining <= r_remaining - AMT_W'(1);
                    if (w_active) begin
                        r_serial_out <= w_bit_out;
                    end
                end
                default: begin
                    r_q <= r_q;
                end
            endcase
        end
    end

    assign q          = r_q;
    assign serial_out = r_serial_out;
    assign busy       = (r_state == ST_SHIFT);
    assign done       = (r_state == ST_DONE);
    assign status     = (r_state == ST_IDLE);

endmodule : shift_reg_seq
`default_nettype wire

// File: tb/tb_shift_reg_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_reg_seq
//  Description : Scoreboard bench for the sequenced shift register
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_data;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amount;
    logic       serial_in;
    logic [7:0] q;
    logic       serial_out;
    logic       busy;
    logic       done;
    logic       status;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [7:0] q;
        logic       so;
        int         cycles;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_q;
    logic       exp_so;

    shift_reg_seq #(.WIDTH(8), .AMT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_data  (load_data),
        .start      (start),
        .mode       (mode),
        .amount     (amount),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done),
        .status     (status)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Reference: apply n single-bit shifts to exp_q/exp_so.
    task automatic model(input logic [2:0] m, input int n, input logic s);
        for (int i = 0; i < n; i++) begin
            case (m)
                3'd1: begin exp_so = exp_q[7]; exp_q = {exp_q[6:0], s}; end
                3'd2: begin exp_so = exp_q[0]; exp_q = {s, exp_q[7:1]}; end
                3'd3: begin exp_so = exp_q[7]; exp_q = {exp_q[6:0], exp_q[7]}; end
                3'd4: begin exp_so = exp_q[0]; exp_q = {exp_q[0], exp_q[7:1]}; end
                3'd5: begin exp_so = exp_q[0]; exp_q = {exp_q[7], exp_q[7:1]}; end
                default: ;
            endcase
        end
    endtask

    // Optionally loads, then runs one sequence; poke disturbs inputs while busy.
    task automatic run_seq(input string name, input bit do_load, input logic [7:0] d,
                           input logic [2:0] m, input int n, input logic s, input bit poke);
        exp_t e;
        int   edges;
        int   busy_cnt;
        int   done_cnt;
        if (do_load) begin
            load = 1'b1; load_data = d;
            cyc();
            load = 1'b0;
            exp_q = d;
            tests_run++;
            if (q !== d) begin
                tests_failed++;
                $display("FAIL %s load: q=%h expected %h", name, q, d);
            end
        end
        model(m, n, s);
        sb.push_back('{q: exp_q, so: exp_so, cycles: n});
        start = 1'b1; mode = m; amount = 4'(n); serial_in = s;
        cyc();
        start = 1'b0;
        edges = 0; busy_cnt = 0; done_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (poke) begin
                start = 1'b1; load = 1'b1; load_data = 8'hFF;
                mode = 3'd1; amount = 4'd1;
            end
            cyc();
            edges++;
        end
        load = 1'b0; start = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (!done || edges != e.cycles) begin
            tests_failed++;
            $display("FAIL %s latency: done after %0d edges (done=%b) expected %0d", name, edges, done, e.cycles);
        end
        tests_run++;
        if (busy_cnt != e.cycles) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: %0d expected %0d", name, busy_cnt, e.cycles);
        end
        tests_run++;
        if (q !== e.q || serial_out !== e.so) begin
            tests_failed++;
            $display("FAIL %s result: q=%h so=%b expected q=%h so=%b", name, q, serial_out, e.q, e.so);
        end
        for (int i = 0; i < 4; i++) begin
            if (done) done_cnt++;
            cyc();
        end
        tests_run++;
        if (done_cnt != 1 || status !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s post: done_pulses=%0d status=%b busy=%b expected 1/1/0", name, done_cnt, status, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        exp_q = 8'h00; exp_so = 1'b0;
        tests_run++;
        if (q !== 8'h00 || serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || status !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: q=%h so=%b busy=%b done=%b status=%b expected 00/0/0/0/1",
                     q, serial_out, busy, done, status);
        end
    endtask

    task automatic test_reset_mid_shift();
        int done_cnt;
        load = 1'b1; load_data = 8'h5A;
        cyc();
        load = 1'b0;
        start = 1'b1; mode = 3'd1; amount = 4'd10; serial_in = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        tests_run++;
        if (q !== 8'h00 || busy !== 1'b0 || status !== 1'b1 || serial_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_shift: q=%h busy=%b status=%b so=%b expected 00/0/1/0", q, busy, status, serial_out);
        end
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) done_cnt++;
            cyc();
        end
        tests_run++;
        if (done_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: %0d done pulses expected 0", done_cnt);
        end
        exp_q = 8'h00; exp_so = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; start = 1'b1; load_data = 8'h3C; mode = 3'd1; amount = 4'd2;
        cyc();
        load = 1'b0; start = 1'b0;
        exp_q = 8'h3C;
        tests_run++;
        if (q !== 8'h3C || status !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_priority: q=%h status=%b busy=%b done=%b expected 3c/1/0/0", q, status, busy, done);
        end
        cyc();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h3C) begin
            tests_failed++;
            $display("FAIL load_priority_idle: busy=%b done=%b q=%h expected 0/0/3c", busy, done, q);
        end
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_data = '0; start = 1'b0;
        mode = '0; amount = '0; serial_in = 1'b0;
        exp_q = '0; exp_so = 1'b0;
        test_reset();
        test_reset_mid_shift();
        run_seq("shl3",     1'b1, 8'hA5, 3'd1, 3,  1'b1, 1'b0);
        run_seq("ror9",     1'b1, 8'h81, 3'd4, 9,  1'b0, 1'b0);
        run_seq("asr3",     1'b1, 8'h80, 3'd5, 3,  1'b0, 1'b0);
        run_seq("amt0",     1'b0, 8'h00, 3'd1, 0,  1'b1, 1'b0);
        test_load_priority();
        run_seq("rol_busy", 1'b0, 8'h00, 3'd3, 4,  1'b0, 1'b1);
        run_seq("mode7",    1'b1, 8'h96, 3'd7, 2,  1'b1, 1'b0);
        run_seq("hold_mid", 1'b1, 8'h69, 3'd0, 5,  1'b1, 1'b1);
        run_seq("shr15",    1'b1, 8'hC3, 3'd2, 15, 1'b1, 1'b0);
        run_seq("rol11",    1'b1, 8'h81, 3'd3, 11, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_shift_reg_seq
`default_nettype wire
